mcdf_arbiter: RTL and testbench
===============================

# mcdf_arbiter

Three-channel packet arbiter for the MCDF datapath, placed between the three slave-channel FIFOs and the formatter. It takes per-channel enable, priority and packet-length settings from the MCDF control register. It grants one enabled, non-empty channel at a time and streams exactly one packet of the configured length to the formatter. Grants are made by priority, with a defined tie-break.

## Interface
Parameters:
- DATA_W, 32, width of channel and formatter data words

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- slvN_valid_i (N=0..2)  in  1  channel N FIFO has a word available
- slvN_data_i (N=0..2)  in  DATA_W  channel N FIFO head word
- slvN_ready_o (N=0..2)  out  1  pop strobe to channel N FIFO; a word is consumed when valid and ready are both high
- slvN_en_i (N=0..2)  in  1  channel enable from control register
- slvN_prio_i (N=0..2)  in  2  channel priority; 0 is highest
- slvN_pkglen_i (N=0..2)  in  3  packet-length code: 0→4, 1→8, 2→16, 3→32 beats, 4–7→32 beats
- fmt_ready_i  in  1  formatter accepts a beat this cycle
- fmt_valid_o  out  1  beat valid to formatter
- fmt_data_o  out  DATA_W  beat data
- fmt_chid_o  out  2  granted channel id
- fmt_length_o  out  6  packet length in beats (4..32), constant for the whole packet
- fmt_start_o  out  1  high on the first beat of a packet, qualified by fmt_valid_o
- fmt_end_o  out  1  high on the last beat of a packet, qualified by fmt_valid_o

## Operation
- A channel is eligible when slvN_en_i=1 and slvN_valid_i=1.
- The FSM has two states, IDLE and SEND.
- **IDLE:**
  - If any channel is eligible, select the eligible channel with the numerically lowest prio.
  - Resolve ties as described under Configuration.
  - Latch the grant id, the decoded length and the lastgrant pointer. Clear the beat counter. Go to SEND.
  - If no channel is eligible, stay in IDLE.
- **SEND:**
  - fmt_valid_o = slv[g]_valid_i.
  - fmt_data_o = slv[g]_data_i.
  - slv[g]_ready_o = fmt_ready_i. All other ready outputs are 0.
  - A beat transfers when fmt_valid_o and fmt_ready_i are both high. The beat counter increments on each transfer.
  - fmt_start_o = (count==0). fmt_end_o = (count==length-1).
  - The transfer of the end beat returns the FSM to IDLE.
- Priority and pkglen are sampled only at grant. Changes during SEND affect only the next packet.
- If slvN_en_i deasserts during SEND, the packet still completes.
- If the granted channel's valid drops mid-packet, the packet stalls. There is no timeout, and other channels are not granted.
- The beat counter is 6 bits and never wraps within a packet; it is cleared at every grant.

## Timing
- Reset values:
  - state=IDLE; fmt_valid_o=0; fmt_start_o=0; fmt_end_o=0.
  - fmt_chid_o=0; fmt_length_o=0; fmt_data_o=0; all slvN_ready_o=0.
  - Beat counter=0; lastgrant=2.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k produces the first beat presentable in cycle k+1.
- Data path is combinational from the granted channel to the formatter: zero latency, no buffering.
- One IDLE bubble follows each packet. An N-beat packet at full throughput occupies N+1 cycles.
- In IDLE, fmt_data_o, fmt_chid_o and fmt_length_o are held at 0.
- fmt_chid_o and fmt_length_o are registered and stable throughout SEND.
- Asserting reset mid-packet aborts the packet immediately. No end beat is emitted.

## Configuration
- Macro: MCDF_ARB_RR_TIE_EN.
- **Defined:** among tied highest-priority eligible channels, grant the first one after lastgrant in cyclic order 0→1→2→0. lastgrant updates at every grant.
- **Undefined:** ties go to the lowest channel index. The lastgrant logic is not compiled.

## Test plan
- **Reset values:** assert reset with stimulus active → all outputs 0, state IDLE. After release with no eligible channel → fmt_valid_o stays 0.
- **Single packet:** ch0 en=1, pkglen=0, valid held high, fmt_ready_i=1 → exactly 4 beats with fmt_chid_o=0 and fmt_length_o=4. fmt_start_o on beat 1, fmt_end_o on beat 4. Then 1 idle cycle.
- **Priority:** ch0 prio=2 and ch1 prio=0, both valid → ch1 packet first, then ch0. A disabled ch2 with valid=1 is never granted.
- **Tie-break:** all three channels prio=1, pkglen=0, continuously valid → grant order 0,1,2,0 with the macro; 0,0,0 without it.
- **Backpressure:** fmt_ready_i low for 3 cycles mid-packet → fmt_data_o is held, no slvN_ready_o pulse, beat counter frozen. The packet resumes and ends with the correct beat count.
- **Mid-packet changes:**
  - Change pkglen 1→3 during SEND → the current packet stays at 8 beats; the next packet is 32 beats.
  - Assert reset mid-packet → immediate IDLE, all outputs 0.

Source files
------------

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: three-channel priority packet arbiter between the slave FIFOs and the formatter.
// Define MCDF_ARB_RR_TIE_EN to break priority ties round-robin instead of by lowest index.
module mcdf_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              slv0_valid_i,
  input  logic [DATA_W-1:0] slv0_data_i,
  output logic              slv0_ready_o,
  input  logic              slv0_en_i,
  input  logic [1:0]        slv0_prio_i,
  input  logic [2:0]        slv0_pkglen_i,
  input  logic              slv1_valid_i,
  input  logic [DATA_W-1:0] slv1_data_i,
  output logic              slv1_ready_o,
  input  logic              slv1_en_i,
  input  logic [1:0]        slv1_prio_i,
  input  logic [2:0]        slv1_pkglen_i,
  input  logic              slv2_valid_i,
  input  logic [DATA_W-1:0] slv2_data_i,
  output logic              slv2_ready_o,
  input  logic              slv2_en_i,
  input  logic [1:0]        slv2_prio_i,
  input  logic [2:0]        slv2_pkglen_i,
  input  logic              fmt_ready_i,
  output logic              fmt_valid_o,
  output logic [DATA_W-1:0] fmt_data_o,
  output logic [1:0]        fmt_chid_o,
  output logic [5:0]        fmt_length_o,
  output logic              fmt_start_o,
  output logic              fmt_end_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state, state_nx;
  logic [1:0] grant_id, grant_nx;
  logic [5:0] length, length_nx;
  logic [5:0] count, count_nx;
  logic [2:0] elig, tied;
  logic [1:0] min_prio, pick;
  logic [2:0] pick_pkglen;
  logic       xfer, last_beat;

  function automatic logic [5:0] decode_len(input logic [2:0] code);
    case (code)
      3'd0:    decode_len = 6'd4;
      3'd1:    decode_len = 6'd8;
      3'd2:    decode_len = 6'd16;
      default: decode_len = 6'd32;
    endcase
  endfunction

  assign elig = {slv2_en_i & slv2_valid_i, slv1_en_i & slv1_valid_i, slv0_en_i & slv0_valid_i};

  // Find the best priority among eligible channels, then every eligible channel holding it.
  always_comb begin
    min_prio = 2'd3;
    if (elig[0] && (slv0_prio_i < min_prio)) min_prio = slv0_prio_i;
    if (elig[1] && (slv1_prio_i < min_prio)) min_prio = slv1_prio_i;
    if (elig[2] && (slv2_prio_i < min_prio)) min_prio = slv2_prio_i;
    tied = {elig[2] && (slv2_prio_i == min_prio),
            elig[1] && (slv1_prio_i == min_prio),
            elig[0] && (slv0_prio_i == min_prio)};
  end

`ifdef MCDF_ARB_RR_TIE_EN
  logic [1:0] lastgrant;

  // Search starts just after the previous winner so equal-priority channels take turns.
  always_comb begin
    case (lastgrant)
      2'd0:    pick = tied[1] ? 2'd1 : (tied[2] ? 2'd2 : 2'd0);
      2'd1:    pick = tied[2] ? 2'd2 : (tied[0] ? 2'd0 : 2'd1);
      default: pick = tied[0] ? 2'd0 : (tied[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                       lastgrant <= 2'd2;
    else if ((state == IDLE) && |elig) lastgrant <= pick;
  end
`else
  always_comb begin
    if (tied[0])      pick = 2'd0;
    else if (tied[1]) pick = 2'd1;
    else              pick = 2'd2;
  end
`endif

  always_comb begin
    case (pick)
      2'd0:    pick_pkglen = slv0_pkglen_i;
      2'd1:    pick_pkglen = slv1_pkglen_i;
      default: pick_pkglen = slv2_pkglen_i;
    endcase
  end

  assign last_beat = (count == length - 6'd1);

  always_comb begin
    state_nx     = state;
    grant_nx     = grant_id;
    length_nx    = length;
    count_nx     = count;
    fmt_valid_o  = 1'b0;
    fmt_data_o   = '0;
    fmt_start_o  = 1'b0;
    fmt_end_o    = 1'b0;
    slv0_ready_o = 1'b0;
    slv1_ready_o = 1'b0;
    slv2_ready_o = 1'b0;
    xfer         = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) begin
          state_nx  = SEND;
          grant_nx  = pick;
          length_nx = decode_len(pick_pkglen);
          count_nx  = 6'd0;
        end
      end
      SEND: begin
        case (grant_id)
          2'd0: begin
            fmt_valid_o  = slv0_valid_i;
            fmt_data_o   = slv0_data_i;
            slv0_ready_o = fmt_ready_i;
          end
          2'd1: begin
            fmt_valid_o  = slv1_valid_i;
            fmt_data_o   = slv1_data_i;
            slv1_ready_o = fmt_ready_i;
          end
          default: begin
            fmt_valid_o  = slv2_valid_i;
            fmt_data_o   = slv2_data_i;
            slv2_ready_o = fmt_ready_i;
          end
        endcase
        fmt_start_o = (count == 6'd0);
        fmt_end_o   = last_beat;
        xfer        = fmt_valid_o & fmt_ready_i;
        // Id and length fall back to zero on exit so the formatter sees 0 while idle.
        if (xfer) begin
          if (last_beat) begin
            state_nx  = IDLE;
            grant_nx  = 2'd0;
            length_nx = 6'd0;
            count_nx  = 6'd0;
          end else begin
            count_nx = count + 6'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      grant_id <= 2'd0;
      length   <= 6'd0;
      count    <= 6'd0;
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      length   <= length_nx;
      count    <= count_nx;
    end
  end

  assign fmt_chid_o   = grant_id;
  assign fmt_length_o = length;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// tb_mcdf_arbiter: table-driven cycle vectors plus hand-written backpressure and
// mid-packet pkglen sequences for mcdf_arbiter.
module tb_mcdf_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        slv0_valid, slv1_valid, slv2_valid;
  logic [31:0] slv0_data, slv1_data, slv2_data;
  logic        slv0_ready, slv1_ready, slv2_ready;
  logic        slv0_en, slv1_en, slv2_en;
  logic [1:0]  slv0_prio, slv1_prio, slv2_prio;
  logic [2:0]  slv0_pkglen, slv1_pkglen, slv2_pkglen;
  logic        fmt_ready, fmt_valid, fmt_start, fmt_end;
  logic [31:0] fmt_data;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;

  int pass_cnt  = 0;
  int check_cnt = 0;

  typedef struct packed {
    logic       rstn;
    logic [2:0] en;
    logic [2:0] valid;
    logic [5:0] prio;
    logic [8:0] pkglen;
    logic       fmt_ready;
    logic       exp_send;
    logic       exp_valid;
    logic       exp_start;
    logic       exp_end;
    logic [1:0] exp_chid;
    logic [5:0] exp_len;
    logic [2:0] exp_ready;
  } vec_t;

  vec_t vecs[$];
  vec_t t;

  mcdf_arbiter #(.DATA_W(32)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .slv0_valid_i(slv0_valid), .slv0_data_i(slv0_data), .slv0_ready_o(slv0_ready),
    .slv0_en_i(slv0_en), .slv0_prio_i(slv0_prio), .slv0_pkglen_i(slv0_pkglen),
    .slv1_valid_i(slv1_valid), .slv1_data_i(slv1_data), .slv1_ready_o(slv1_ready),
    .slv1_en_i(slv1_en), .slv1_prio_i(slv1_prio), .slv1_pkglen_i(slv1_pkglen),
    .slv2_valid_i(slv2_valid), .slv2_data_i(slv2_data), .slv2_ready_o(slv2_ready),
    .slv2_en_i(slv2_en), .slv2_prio_i(slv2_prio), .slv2_pkglen_i(slv2_pkglen),
    .fmt_ready_i(fmt_ready), .fmt_valid_o(fmt_valid), .fmt_data_o(fmt_data),
    .fmt_chid_o(fmt_chid), .fmt_length_o(fmt_length),
    .fmt_start_o(fmt_start), .fmt_end_o(fmt_end)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] chanWord(input int ch);
    return 32'hDA7A_0000 + 32'(ch);
  endfunction

  function automatic logic [31:0] dataWord(input int ch, input int k);
    return 32'h5000_0000 | (32'(ch) << 16) | 32'(k);
  endfunction

  function automatic int tieCh(input int p);
`ifdef MCDF_ARB_RR_TIE_EN
    return p % 3;
`else
    return 0 * p;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    rstn        = v.rstn;
    slv0_en     = v.en[0];
    slv1_en     = v.en[1];
    slv2_en     = v.en[2];
    slv0_valid  = v.valid[0];
    slv1_valid  = v.valid[1];
    slv2_valid  = v.valid[2];
    slv0_prio   = v.prio[1:0];
    slv1_prio   = v.prio[3:2];
    slv2_prio   = v.prio[5:4];
    slv0_pkglen = v.pkglen[2:0];
    slv1_pkglen = v.pkglen[5:3];
    slv2_pkglen = v.pkglen[8:6];
    slv0_data   = chanWord(0);
    slv1_data   = chanWord(1);
    slv2_data   = chanWord(2);
    fmt_ready   = v.fmt_ready;
  endtask

  task automatic addIdle();
    vec_t v;
    v = t;
    v.exp_send = 0; v.exp_valid = 0; v.exp_start = 0; v.exp_end = 0;
    v.exp_chid = 0; v.exp_len = 0; v.exp_ready = 0;
    vecs.push_back(v);
  endtask

  task automatic addReset();
    vec_t v;
    v = t;
    v.rstn = 0;
    v.exp_send = 0; v.exp_valid = 0; v.exp_start = 0; v.exp_end = 0;
    v.exp_chid = 0; v.exp_len = 0; v.exp_ready = 0;
    vecs.push_back(v);
  endtask

  task automatic addBeatRange(input int ch, input int len, input int b0, input int b1);
    vec_t v;
    for (int b = b0; b <= b1; b++) begin
      v = t;
      v.exp_send  = 1;
      v.exp_valid = 1;
      v.exp_start = (b == 0);
      v.exp_end   = (b == len - 1);
      v.exp_chid  = 2'(ch);
      v.exp_len   = 6'(len);
      v.exp_ready = t.fmt_ready ? 3'(1 << ch) : 3'd0;
      vecs.push_back(v);
    end
  endtask

  task automatic setChan(input int ch, input logic valid, input logic [31:0] data);
    case (ch)
      0:       begin slv0_valid = valid; slv0_data = data; end
      1:       begin slv1_valid = valid; slv1_data = data; end
      default: begin slv2_valid = valid; slv2_data = data; end
    endcase
  endtask

  // Idle/grant cycle first, then beats until the end beat; the bubble is checked by the next call.
  task automatic sendAndCheck(input int ch, input int len, input int stall_at, input int stall_len,
                              input int chg_at, input logic [2:0] chg_code);
    int   k;
    int   stall_left;
    int   cyc;
    logic rdy;
    k = 0; stall_left = stall_len; cyc = 0;
    @(posedge clk); #1;
    fmt_ready = 1;
    setChan(ch, 1'b1, dataWord(ch, 0));
    @(negedge clk);
    checkOutput("grant_cycle_valid", 32'(fmt_valid), 32'd0);
    checkOutput("grant_cycle_chid", 32'(fmt_chid), 32'd0);
    while (k < len && cyc < 200) begin
      @(posedge clk); #1;
      if (k == chg_at) slv0_pkglen = chg_code;
      rdy = !(k == stall_at && stall_left > 0);
      if (!rdy) stall_left--;
      fmt_ready = rdy;
      setChan(ch, 1'b1, dataWord(ch, k));
      @(negedge clk);
      checkOutput($sformatf("pkt_data_b%0d", k), fmt_data, dataWord(ch, k));
      checkOutput($sformatf("pkt_valid_b%0d", k), 32'(fmt_valid), 32'd1);
      checkOutput($sformatf("pkt_chid_b%0d", k), 32'(fmt_chid), 32'(ch));
      checkOutput($sformatf("pkt_len_b%0d", k), 32'(fmt_length), 32'(len));
      checkOutput($sformatf("pkt_start_b%0d", k), 32'(fmt_start), 32'(k == 0));
      checkOutput($sformatf("pkt_end_b%0d", k), 32'(fmt_end), 32'(k == len - 1));
      checkOutput($sformatf("pkt_ready_b%0d", k), 32'({slv2_ready, slv1_ready, slv0_ready}),
                  rdy ? 32'(1 << ch) : 32'd0);
      if (rdy) k++;
      cyc++;
    end
    if (k != len) checkOutput("pkt_beats_timeout", 32'(k), 32'(len));
  endtask

  initial begin
    vec_t v;
    applyStimulus('0);

    // Reset with stimulus active, then release with nothing eligible.
    t = '0;
    t.rstn = 1; t.en = 3'b111; t.valid = 3'b111; t.fmt_ready = 1;
    addReset(); addReset();
    t.valid = 3'b000;
    addIdle(); addIdle();

    // Single 4-beat packet on ch0, one bubble, next packet starts.
    t.en = 3'b001; t.valid = 3'b001; t.prio = '0; t.pkglen = '0;
    addIdle(); addBeatRange(0, 4, 0, 3); addIdle(); addBeatRange(0, 4, 0, 0);
    addReset();

    // Priority: ch1 (prio 0) beats ch0 (prio 2); disabled ch2 is ignored.
    t.en = 3'b011; t.valid = 3'b111; t.prio = {2'd0, 2'd0, 2'd2}; t.pkglen = '0;
    addIdle(); addBeatRange(1, 4, 0, 3);
    t.valid = 3'b101;
    addIdle(); addBeatRange(0, 4, 0, 3); addIdle();
    addReset();

    // Tie-break with all channels at prio 1.
    t.en = 3'b111; t.valid = 3'b111; t.prio = {2'd1, 2'd1, 2'd1}; t.pkglen = '0;
    for (int p = 0; p < 4; p++) begin
      addIdle(); addBeatRange(tieCh(p), 4, 0, 3);
    end
    addReset();

    // Reset mid-packet aborts without an end beat.
    t.en = 3'b001; t.valid = 3'b001; t.prio = '0; t.pkglen = '0;
    addIdle(); addBeatRange(0, 4, 0, 1); addReset(); addIdle(); addBeatRange(0, 4, 0, 0);
    addReset();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid", i), 32'(fmt_valid), 32'(v.exp_valid));
      checkOutput($sformatf("v%0d_data", i), fmt_data, v.exp_send ? chanWord(int'(v.exp_chid)) : 32'd0);
      checkOutput($sformatf("v%0d_chid", i), 32'(fmt_chid), 32'(v.exp_chid));
      checkOutput($sformatf("v%0d_len", i), 32'(fmt_length), 32'(v.exp_len));
      checkOutput($sformatf("v%0d_start", i), 32'(fmt_start), 32'(v.exp_start));
      checkOutput($sformatf("v%0d_end", i), 32'(fmt_end), 32'(v.exp_end));
      checkOutput($sformatf("v%0d_ready", i), 32'({slv2_ready, slv1_ready, slv0_ready}), 32'(v.exp_ready));
    end

    // Backpressure: 3 stalled cycles at beat 3 of an 8-beat ch1 packet.
    @(posedge clk); #1;
    slv0_en = 0; slv2_en = 0; slv0_valid = 0; slv1_valid = 0; slv2_valid = 0;
    slv1_en = 1; slv1_prio = 2'd0; slv1_pkglen = 3'd1; fmt_ready = 1;
    rstn = 1;
    sendAndCheck(1, 8, 3, 3, -1, 3'd0);

    @(posedge clk); #1;
    slv1_valid = 0; slv1_en = 0;
    @(negedge clk);
    checkOutput("bp_bubble_valid", 32'(fmt_valid), 32'd0);
    checkOutput("bp_bubble_len", 32'(fmt_length), 32'd0);

    // pkglen 1 -> 3 during SEND: this packet stays 8, the next is 32.
    slv0_en = 1; slv0_prio = 2'd0; slv0_pkglen = 3'd1; slv0_valid = 0;
    sendAndCheck(0, 8, -1, 0, 2, 3'd3);
    sendAndCheck(0, 32, -1, 0, -1, 3'd0);
    @(posedge clk); #1;
    slv0_valid = 0;
    @(negedge clk);
    checkOutput("final_bubble_valid", 32'(fmt_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
